// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store engine for the RV32IM memory stage.
// It steers byte lanes, sign/zero extends load data, checks alignment and
// stalls the pipeline until each access on the req/ack data bus completes.
// Optional feature macro: LSU_TIMEOUT_EN aborts a request with bus_err after
// TIMEOUT REQ cycles without bus_ack. When it is undefined, REQ waits forever
// and bus_err is tied low.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_Read,
    input  logic        Mem_Write,
    input  logic [1:0]  Mem_Read_Type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [1:0] T_WORD = 2'b00;
    localparam logic [1:0] T_HALF = 2'b01;
    localparam logic [1:0] T_BYTE_S = 2'b10;

    state_t      r_state;
    logic        r_is_load;
    logic [1:0]  r_type;
    logic [1:0]  r_lane;
    logic        r_done;
    logic        r_misalign;
    logic [31:0] r_rdata;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;

    logic        w_start;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic        w_timeout;

    assign w_start = MEM_Read | Mem_Write;

    // Stall is combinational on the request while idle, and held through REQ.
    assign stall = (r_state == S_REQ) || ((r_state == S_IDLE) && w_start);

    // Decode the incoming request: alignment, byte enables and lane-replicated store data.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_misalign = 1'b0;
        w_be       = 4'b0001 << addr[1:0];
        w_wdata    = {4{wdata[7:0]}};
        case (Mem_Read_Type)
            T_WORD: begin
                w_misalign = (addr[1:0] != 2'b00);
                w_be       = 4'b1111;
                w_wdata    = wdata;
            end
            T_HALF: begin
                w_misalign = addr[0];
                w_be       = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Extract and extend the addressed lane of the returned read word.
    always_comb begin
        w_byte      = bus_rdata[8*r_lane +: 8];
        w_half      = bus_rdata[16*r_lane[1] +: 16];
        w_load_data = {24'b0, w_byte};
        case (r_type)
            T_WORD:   w_load_data = bus_rdata;
            T_HALF:   w_load_data = {{16{w_half[15]}}, w_half};
            T_BYTE_S: w_load_data = {{24{w_byte[7]}}, w_byte};
            default:  ;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_bus_err;

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign bus_err   = r_bus_err;

    // Count REQ cycles; flag bus_err for the DONE cycle that follows an expired wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_cnt     <= (r_state == S_REQ) ? r_cnt + 1'b1 : '0;
            r_bus_err <= (r_state == S_REQ) && !bus_ack && w_timeout;
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
    assign bus_err          = 1'b0;
`endif

    // Access FSM: accept in IDLE, hold the bus in REQ, pulse completion in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state and outputs use non-blocking assignments so every
            // read in this block sees the pre-edge value.
            r_state     <= S_IDLE;
            r_is_load   <= 1'b0;
            r_type      <= 2'b00;
            r_lane      <= 2'b00;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_rdata     <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_is_load   <= !Mem_Write;
                        r_type      <= Mem_Read_Type;
                        r_lane      <= addr[1:0];
                        r_bus_we    <= Mem_Write;
                        r_bus_addr  <= {addr[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        if (w_misalign) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_misalign <= 1'b1;
                            r_rdata    <= '0;
                        end else begin
                            r_state   <= S_REQ;
                            r_bus_req <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        r_state   <= S_DONE;
                        r_bus_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_rdata   <= r_is_load ? w_load_data : '0;
                    end else if (w_timeout) begin
                        r_state   <= S_DONE;
                        r_bus_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_rdata   <= '0;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_done     <= 1'b0;
                    r_misalign <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign done      = r_done;
    assign misalign  = r_misalign;
    assign rdata     = r_rdata;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan cases, randomized
// accesses against a behavioural model, back-to-back issue, stray acks,
// mid-access reset and the REQ wait limit (build-dependent).
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MEM_Read = 1'b0;
    logic        Mem_Write = 1'b0;
    logic [1:0]  Mem_Read_Type = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall, done, misalign, bus_err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_Read(MEM_Read), .Mem_Write(Mem_Write), .Mem_Read_Type(Mem_Read_Type),
        .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata), .misalign(misalign), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    // ---------------- behavioural reference model ----------------
    function automatic bit model_misaligned(bit [1:0] ty, bit [31:0] a);
        if (ty == 2'd0) return (a % 4) != 0;
        if (ty == 2'd1) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic bit [3:0] model_be(bit [1:0] ty, bit [31:0] a);
        int lane = int'(a % 4);
        if (ty == 2'd0) return 4'd15;
        if (ty == 2'd1) return (lane >= 2) ? 4'd12 : 4'd3;
        return 4'(1 << lane);
    endfunction

    function automatic bit [31:0] model_wdata(bit [1:0] ty, bit [31:0] wd);
        if (ty == 2'd0) return wd;
        if (ty == 2'd1) return (wd % 65536) * 32'd65537;
        return (wd % 256) * 32'h0101_0101;
    endfunction

    function automatic bit [31:0] model_load(bit [1:0] ty, bit [31:0] a, bit [31:0] brd);
        longint v;
        int lane = int'(a % 4);
        if (ty == 2'd0) return brd;
        if (ty == 2'd1) begin
            v = longint'((brd >> (16 * (lane / 2))) % 65536);
            if (v >= 32768) v = v - 65536;
            return 32'(v);
        end
        v = longint'((brd >> (8 * lane)) % 256);
        if (ty == 2'd2 && v >= 128) v = v - 256;
        return 32'(v);
    endfunction

    // One complete access starting at posedge+1 in IDLE; ends at posedge+1 back in IDLE.
    task automatic access(input string tag, input bit rd, input bit wr, input bit [1:0] ty,
                          input bit [31:0] a, input bit [31:0] wd, input bit [31:0] brd,
                          input int wait_c);
        bit        exp_mis = model_misaligned(ty, a);
        bit [69:0] exp_bus = {1'b1, wr, a - (a % 4), model_be(ty, a), model_wdata(ty, wd)};
        bit [31:0] exp_rd  = wr ? 32'd0 : model_load(ty, a, brd);
        MEM_Read = rd; Mem_Write = wr; Mem_Read_Type = ty; addr = a; wdata = wd;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b1) begin
            n_err++; $display("FAIL %s stall_c0: got %b want 1", tag, stall);
        end
        @(posedge clk); #1;
        MEM_Read = 1'b0; Mem_Write = 1'b0; addr = $urandom; wdata = $urandom;
        Mem_Read_Type = 2'($urandom);
        if (exp_mis) begin
            @(negedge clk);
            n_cmp++;
            if ({done, misalign, bus_err, bus_req, stall, rdata} !== {5'b11000, 32'd0}) begin
                n_err++;
                $display("FAIL %s misalign_c1: got d/m/e/req/stall=%b%b%b%b%b rdata=%h want 11000 rdata=0",
                         tag, done, misalign, bus_err, bus_req, stall, rdata);
            end
        end else begin
            for (int c = 0; c <= wait_c; c++) begin
                if (c == wait_c) begin
                    bus_ack = 1'b1; bus_rdata = brd;
                end
                @(negedge clk);
                n_cmp++;
                if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, stall, done} !== {exp_bus, 2'b10}) begin
                    n_err++;
                    $display("FAIL %s req_c%0d: got bus=%h stall=%b done=%b want bus=%h stall=1 done=0",
                             tag, c + 1, {bus_req, bus_we, bus_addr, bus_be, bus_wdata}, stall, done, exp_bus);
                end
                @(posedge clk); #1;
            end
            bus_ack = 1'b0; bus_rdata = $urandom;
            @(negedge clk);
            n_cmp++;
            if ({done, misalign, bus_err, bus_req, stall, rdata} !== {5'b10000, exp_rd}) begin
                n_err++;
                $display("FAIL %s done_c%0d: got d/m/e/req/stall=%b%b%b%b%b rdata=%h want 10000 rdata=%h",
                         tag, wait_c + 2, done, misalign, bus_err, bus_req, stall, rdata, exp_rd);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({stall, done, rdata, misalign, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got stall=%b done=%b rdata=%h req=%b addr=%h be=%h wd=%h want all 0",
                     stall, done, rdata, bus_req, bus_addr, bus_be, bus_wdata);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_plan();
        access("lw_100", 1, 0, 2'b00, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        access("lb_103", 1, 0, 2'b10, 32'h103, 32'h0, 32'h8012_3456, 0);
        access("lbu_103", 1, 0, 2'b11, 32'h103, 32'h0, 32'h8012_3456, 0);
        access("sh_202", 0, 1, 2'b01, 32'h202, 32'h0000_ABCD, 32'h1111_1111, 3);
        access("lw_101", 1, 0, 2'b00, 32'h101, 32'h0, 32'h0, 0);
        access("both_sb", 1, 1, 2'b11, 32'h401, 32'h1234_56A5, 32'h0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            bit rd = 1'($urandom);
            bit wr = !rd || (($urandom % 4) == 0);
            access($sformatf("rand%0d", i), rd, wr, 2'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 4)));
        end
    endtask

    task automatic test_back_to_back();
        bit        exp_done;
        bit        exp_stall;
        MEM_Read = 1'b1; Mem_Read_Type = 2'b00; addr = 32'h40; bus_ack = 1'b1; bus_rdata = 32'hA5A5_0F0F;
        for (int i = 0; i < 9; i++) begin
            exp_done  = (i % 3) == 2;
            exp_stall = (i % 3) != 2;
            @(negedge clk);
            n_cmp++;
            if ({done, stall} !== {exp_done, exp_stall} || (exp_done && rdata !== 32'hA5A5_0F0F)) begin
                n_err++;
                $display("FAIL b2b_c%0d: got done=%b stall=%b rdata=%h want done=%b stall=%b rdata=a5a50f0f",
                         i, done, stall, rdata, exp_done, exp_stall);
            end
            @(posedge clk); #1;
        end
        MEM_Read = 1'b0; bus_ack = 1'b0;
    endtask

    task automatic test_stray_ack();
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({done, bus_req, stall} !== 3'b000) begin
                n_err++;
                $display("FAIL stray_ack_c%0d: got done/req/stall=%b%b%b want 000", i, done, bus_req, stall);
            end
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_mid_reset();
        MEM_Read = 1'b1; Mem_Read_Type = 2'b00; addr = 32'h300;
        @(posedge clk); #1;
        MEM_Read = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus_req, stall, done} !== 3'b000) begin
            n_err++;
            $display("FAIL midreset_async: got req/stall/done=%b%b%b want 000", bus_req, stall, done);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({done, bus_req} !== 2'b00) begin
                n_err++;
                $display("FAIL midreset_lost_c%0d: got done/req=%b%b want 00", i, done, bus_req);
            end
        end
        @(posedge clk); #1;
        access("after_reset", 1, 0, 2'b01, 32'h306, 32'h0, 32'h7FFF_8001, 1);
    endtask

    task automatic test_wait_limit();
        MEM_Read = 1'b1; Mem_Read_Type = 2'b00; addr = 32'h80;
        @(posedge clk); #1;
        MEM_Read = 1'b0;
`ifdef LSU_TIMEOUT_EN
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus_req, stall, done} !== 3'b110) begin
                n_err++;
                $display("FAIL timeout_req_c%0d: got req/stall/done=%b%b%b want 110", c, bus_req, stall, done);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++;
        if ({done, bus_err, bus_req, stall, rdata} !== {4'b1100, 32'd0}) begin
            n_err++;
            $display("FAIL timeout_done: got done/err/req/stall=%b%b%b%b rdata=%h want 1100 rdata=0",
                     done, bus_err, bus_req, stall, rdata);
        end
        @(posedge clk); #1;
        access("ack_last_cycle", 1, 0, 2'b00, 32'h84, 32'h0, 32'h0BAD_F00D, TO - 1);
`else
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus_req, stall, done, bus_err} !== 4'b1100) begin
                n_err++;
                $display("FAIL wait_forever_c%0d: got req/stall/done/err=%b%b%b%b want 1100",
                         c, bus_req, stall, done, bus_err);
            end
            @(posedge clk); #1;
        end
        bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({done, rdata} !== {1'b1, 32'h1357_9BDF}) begin
            n_err++;
            $display("FAIL wait_forever_done: got done=%b rdata=%h want 1 13579bdf", done, rdata);
        end
        @(posedge clk); #1;
`endif
    endtask

    initial begin
        test_reset();
        test_plan();
        test_random();
        test_back_to_back();
        test_stray_ack();
        test_mid_reset();
        test_wait_limit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
